// File: rtl/unified_mem_arbiter.sv
// Arbiter that shares one single-ported, variable-latency memory between instruction fetch
// (read-only) and the data stage (read/write), with one transaction in flight at a time.
module unified_mem_arbiter #(
  parameter int AW             = 16,
  parameter int DW             = 16,
  parameter int MAX_DATA_BURST = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_kill,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          stall_f,
  output logic          stall_m,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [2:0]    dbg_state
);

  localparam int BW = $clog2(MAX_DATA_BURST + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    F_BUSY = 3'd1,
    D_BUSY = 3'd2,
    F_DONE = 3'd3,
    D_DONE = 3'd4
  } state_t;

  state_t        state;
  logic [BW-1:0] burst_cnt;
  logic          discard;

  logic fetch_pend;
  logic burst_full;
  logic grant_d;
  logic grant_f;

  // Handshake: if_req/d_req are levels held until the matching one-cycle ready pulse, and the
  // requester advances on the edge that ends that pulse. Toward memory, mem_req rises the cycle
  // after a grant and mem_we/mem_addr/mem_wdata stay frozen until the cycle mem_ack is seen.
  always_comb begin
    fetch_pend = if_req & ~if_kill;
    burst_full = (burst_cnt == BW'(MAX_DATA_BURST));
    grant_d    = d_req & ~(fetch_pend & burst_full);
    grant_f    = fetch_pend & ~grant_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      burst_cnt <= '0;
      discard   <= 1'b0;
      if_rdata  <= '0;
      if_ready  <= 1'b0;
      d_rdata   <= '0;
      d_ready   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= D_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            // Count data grants that bypassed a waiting fetch; saturating value forces a fetch turn.
            if (!fetch_pend)
              burst_cnt <= '0;
            else if (!burst_full)
              burst_cnt <= burst_cnt + BW'(1);
          end else if (grant_f) begin
            state     <= F_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            burst_cnt <= '0;
          end
        end
        F_BUSY: begin
          if (if_kill)
            discard <= 1'b1;
          if (mem_ack) begin
            if (!(discard | if_kill)) begin
              if_rdata <= mem_rdata;
              if_ready <= 1'b1;
            end
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= F_DONE;
          end
        end
        D_BUSY: begin
          if (mem_ack) begin
            if (!mem_we)
              d_rdata <= mem_rdata;
            d_ready <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= D_DONE;
          end
        end
        F_DONE: begin
          if_ready <= 1'b0;
          discard  <= 1'b0;
          state    <= IDLE;
        end
        D_DONE: begin
          d_ready <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stalls are combinational so the pipeline sees them in the request cycle; reset forces them low.
  assign stall_f   = reset & if_req & ~if_ready & ~if_kill;
  assign stall_m   = reset & d_req & ~d_ready;
  assign dbg_state = state;

endmodule
